// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage feeding the main decoder. Owns the PC, fetches one
//   32-bit word at a time over a req/ack handshake, holds it in the instruction
//   register until the datapath retires it, then steps to the next PC chosen
//   by Jr > Jump > taken Branch > sequential.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata    instruction memory handshake (addr == pc)
//   instr, opcode, funct       latched instruction and its decode slices
//   pc, pc_plus4               address of instr and its successor
//   instr_valid                instr holds a fetched word
//   advance, stall             retire current instr / hold (stall wins)
//   Jump, Branch, branch_cond  control from decode, sampled when advancing
//   Jr, rs_data                register-indirect jump and its target
//   fetch_error                sticky: memory timeout or misaligned target
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        branch_cond,
  input  logic        Jr,
  input  logic [31:0] rs_data,
  output logic        fetch_error
);

  typedef enum logic [1:0] {S_REQ, S_VALID, S_ERROR} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [31:0] pc_d, instr_d, next_pc, br_off;
  logic        vld_d, err_d;
  // Cleared by reset and set on the first clock after release, so a request
  // (and any ack) only counts from that clock on; an ack still in flight from
  // a request abandoned by reset is never taken as data.
  logic        req_en;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    if (Jr)                       next_pc = rs_data;
    else if (Jump)                next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (Branch && branch_cond) next_pc = pc_plus4 + br_off;
    else                          next_pc = pc_plus4;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pc_d     = pc;
    instr_d  = instr;
    vld_d    = instr_valid;
    err_d    = fetch_error;
    imem_req = 1'b0;
    case (state)
      S_REQ: begin
        if (req_en) begin
          imem_req = 1'b1;
          // ack has priority over the timeout in the last allowed cycle
          if (imem_ack) begin
            instr_d = imem_rdata;
            vld_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = S_VALID;
          end else if (cnt == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_VALID: begin
        if (advance && !stall) begin
          pc_d  = next_pc;
          vld_d = 1'b0;
          // misaligned target: park pc on it and never request it
          if (next_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_ERROR: begin
        vld_d = 1'b0;
        err_d = 1'b1;
      end
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      cnt         <= 16'd0;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
      req_en      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= vld_d;
      fetch_error <= err_d;
      req_en      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [31:0] pc, pc_plus4;
  logic        instr_valid;
  logic        advance, stall, Jump, Branch, branch_cond, Jr;
  logic [31:0] rs_data;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] cur_addr = 32'h0;
  logic        req_q = 1'b0, vld_q = 1'b0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .advance(advance), .stall(stall), .Jump(Jump), .Branch(Branch),
    .branch_cond(branch_cond), .Jr(Jr), .rs_data(rs_data), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch: expected address/word go to the scoreboard first, then
  // wait for the request and ack it after dly cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int dly);
    int n = 0;
    addr_q.push_back(a);
    instr_q.push_back(w);
    while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    if (imem_req !== 1'b1) begin
      chk("req_wait", {31'b0, imem_req}, 32'd1);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic adv(input logic j, input logic b, input logic c, input logic r,
                     input logic [31:0] rs);
    Jump = j; Branch = b; branch_cond = c; Jr = r; rs_data = rs; advance = 1'b1;
    tick();
    Jump = 0; Branch = 0; branch_cond = 0; Jr = 0; rs_data = 32'h0; advance = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a request or a new instr appears.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      if (imem_req && !req_q) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
        end else begin
          chk("req_addr", imem_addr, addr_q[0]);
          cur_addr <= addr_q[0];
          void'(addr_q.pop_front());
        end
      end else if (imem_req) begin
        chk("addr_stable", imem_addr, cur_addr);
      end
      if (instr_valid && !vld_q) begin
        if (instr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_instr: instr %h, none expected", instr);
        end else begin
          chk("instr", instr, instr_q[0]);
          chk("opcode", {26'b0, opcode}, {26'b0, instr_q[0][31:26]});
          chk("funct", {26'b0, funct}, {26'b0, instr_q[0][5:0]});
          chk("instr_pc", pc, cur_addr);
          void'(instr_q.pop_front());
        end
      end
      req_q <= imem_req;
      vld_q <= instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; imem_ack = 0; imem_rdata = 0; advance = 0; stall = 0;
    Jump = 0; Branch = 0; branch_cond = 0; Jr = 0; rs_data = 0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_error}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    tick();
    rst_n = 1;

    // first fetch, ack in the first request cycle
    fetch(32'h0, 32'h2008_0005, 0);
    chk("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    chk("opcode_addi", {26'b0, opcode}, 32'h08);
    chk("pc_plus4", pc_plus4, 32'h4);
    adv(0, 0, 0, 0, 32'h0);
    chk("pc_seq", pc, 32'h4);
    chk("valid_clr", {31'b0, instr_valid}, 32'd0);

    fetch(32'h4, 32'h0800_0004, 0);           // j -> 0x10
    adv(1, 0, 0, 0, 32'h0);
    chk("pc_jump_0x10", pc, 32'h10);

    fetch(32'h10, 32'h1000_FFFE, 0);          // beq, imm -2
    adv(0, 1, 1, 0, 32'h0);
    chk("pc_br_taken", pc, 32'h0C);

    // delayed ack, then stall with advance held high
    fetch(32'h0C, 32'h1000_FFFE, 3);
    stall = 1; advance = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", pc, 32'h0C);
      chk("stall_instr", instr, 32'h1000_FFFE);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 0; advance = 0;
    adv(0, 1, 0, 0, 32'h0);
    chk("pc_br_nt_0c", pc, 32'h10);

    fetch(32'h10, 32'h1000_FFFE, 0);
    adv(0, 1, 0, 0, 32'h0);
    chk("pc_br_not_taken", pc, 32'h14);

    fetch(32'h14, 32'h0000_0020, 0);
    adv(0, 0, 0, 1, 32'h1000_0000);
    chk("pc_jr", pc, 32'h1000_0000);

    fetch(32'h1000_0000, 32'h0800_0040, 0);
    adv(1, 0, 0, 0, 32'h0);
    chk("pc_jump_region", pc, 32'h1000_0100);

    fetch(32'h1000_0100, 32'h0800_0040, 0);
    adv(1, 0, 0, 1, 32'h200);
    chk("pc_jr_over_jump", pc, 32'h200);

    fetch(32'h200, 32'h0800_0010, 0);
    adv(1, 1, 1, 0, 32'h0);
    chk("pc_jump_over_br", pc, 32'h40);

    fetch(32'h40, 32'h0, 0);
    adv(0, 0, 0, 1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0, 1);
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    adv(0, 0, 0, 0, 32'h0);
    chk("pc_wrap", pc, 32'h0);

    // misaligned jr target
    fetch(32'h0, 32'h0000_0008, 0);
    chk("funct_jr", {26'b0, funct}, 32'h08);
    adv(0, 0, 0, 1, 32'h203);
    chk("mis_err", {31'b0, fetch_error}, 32'd1);
    chk("mis_pc", pc, 32'h203);
    chk("mis_req", {31'b0, imem_req}, 32'd0);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    advance = 1; imem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_sticky", {31'b0, fetch_error}, 32'd1);
      chk("mis_pc_hold", pc, 32'h203);
    end
    advance = 0; imem_ack = 0;

    // reset clears the error; then let the fetch time out
    rst_n = 0;
    #1;
    chk("rst_err_clr", {31'b0, fetch_error}, 32'd0);
    chk("rst_pc_clr", pc, 32'h0);
    tick();
    rst_n = 1;
    addr_q.push_back(32'h0);
    tick();
    chk("to_req", {31'b0, imem_req}, 32'd1);
    repeat (7) tick();
    chk("to_err_early", {31'b0, fetch_error}, 32'd0);
    chk("to_req_late", {31'b0, imem_req}, 32'd1);
    tick();
    chk("to_err", {31'b0, fetch_error}, 32'd1);
    chk("to_req_drop", {31'b0, imem_req}, 32'd0);
    chk("to_valid", {31'b0, instr_valid}, 32'd0);
    chk("to_pc", pc, 32'h0);
    imem_ack = 1; imem_rdata = 32'h1234_5678; advance = 1;
    repeat (2) tick();
    imem_ack = 0; imem_rdata = 0; advance = 0;
    chk("to_sticky", {31'b0, fetch_error}, 32'd1);
    chk("to_ack_ignored", {31'b0, instr_valid}, 32'd0);

    // ack in the last allowed cycle beats the timeout
    rst_n = 0;
    #1;
    tick();
    rst_n = 1;
    addr_q.push_back(32'h0);
    instr_q.push_back(32'h2008_0005);
    tick();
    repeat (7) tick();
    imem_ack = 1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ack = 0; imem_rdata = 0;
    chk("ackwin_err", {31'b0, fetch_error}, 32'd0);
    chk("ackwin_valid", {31'b0, instr_valid}, 32'd1);

    // async reset in the middle of a fetch
    adv(0, 0, 0, 0, 32'h0);
    addr_q.push_back(32'h4);
    tick();
    #3;
    rst_n = 0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_instr", instr, 32'h0);
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_ack = 0; imem_rdata = 0;
    chk("async_ack_ign", instr, 32'h0);
    rst_n = 1;
    chk("rel_req_low", {31'b0, imem_req}, 32'd0);
    fetch(32'h0, 32'h2008_0005, 0);
    chk("rel_valid", {31'b0, instr_valid}, 32'd1);

    tick(); tick();
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("instr_q_empty", 32'(instr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
